fetch_unit: RTL and testbench

Instruction fetch stage feeding the instruction decoder. Holds the program counter, issues in-order word fetches to instruction memory over a valid/ready request channel, and buffers returned instruction words in a small FIFO. It presents {instruction, PC} pairs to the decoder with a valid/ready handshake. Branch and jump redirects flush buffered and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_buffer.sv | 61 ++++++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: datapath width,
// instruction size, the canonical NOP encoding, the credit counter type
// used for buffer/outstanding bookkeeping and the buffer entry layout.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0 -- harmless filler for buffer slots that were never written
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Wide enough for count + outstanding on any practical buffer depth
    localparam int CREDIT_W = 8;
    typedef logic [CREDIT_W-1:0] credit_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] code;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits are simply dropped
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer
// Circular FIFO of {pc, code} pairs sitting between instruction memory and
// the decoder. Read and write pointers wrap naturally because DEPTH is a
// power of two. Flush empties the FIFO in one cycle and wins over push/pop.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push         write push_entry at the tail
//   push_entry   {pc, code} to store
//   pop          drop the head entry
//   flush        discard all entries
//   head         entry at the read pointer (only meaningful when count != 0)
//   count        number of buffered entries (0..DEPTH)
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output credit_t      count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: '0, code: NOP_INSTR};
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + credit_t'(push) - credit_t'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Owns the program counter, issues in-order word
// fetches over a valid/ready request channel, tags each accepted request
// with its address, buffers returned words and hands {code, pc} pairs to
// the decoder. A redirect flushes the buffer and silently drops every
// response still in flight.
// Optional build macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect
// raises a sticky fetch_fault and stalls fetching until an aligned redirect.
// Without it the low two bits of redirect_pc are ignored.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req_valid/ready/addr request channel to instruction memory
//   imem_resp_valid/data      in-order responses, never back-pressured
//   redirect_valid/pc         taken branch/jump, one cycle pulse
//   inst_valid/ready          handshake to the decoder
//   inst_code/inst_pc         instruction word and its address
//   fetch_fault               misaligned redirect trap (macro builds only)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_code,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam int TAG_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_PTR_W-1:0] TAG_ONE = TAG_PTR_W'(1);

    logic [XLEN-1:0]      fetch_pc;
    credit_t              outstanding;
    credit_t              discard;
    credit_t              buf_count;
    logic                 req_fire;
    logic                 resp_live;
    logic                 req_block;
    fetch_entry_t         head;
    fetch_entry_t         last_entry;
    fetch_entry_t         push_entry;
    logic [XLEN-1:0]      tag_q [DEPTH];
    logic [TAG_PTR_W-1:0] tag_wr;
    logic [TAG_PTR_W-1:0] tag_rd;

    // Only request while every possible response still has a buffer slot
    // waiting for it; this is what makes buffer overflow impossible.
    always_comb begin
        imem_req_valid = !rst && !redirect_valid && !req_block &&
                         ((buf_count + outstanding) < credit_t'(DEPTH));
    end

    assign imem_req_addr = fetch_pc;
    assign req_fire      = imem_req_valid && imem_req_ready;
    // A response is kept only if nothing stale is still draining and no
    // redirect is flushing the buffer in the same cycle.
    assign resp_live     = imem_resp_valid && !redirect_valid && (discard == '0);
    assign push_entry    = '{pc: tag_q[tag_rd], code: imem_resp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        end
    end

    // Outstanding counts every request still owed a response, including
    // ones that will be discarded, so credit stays honest across redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + credit_t'(req_fire) - credit_t'(imem_resp_valid);
        end
    end

    // On redirect every response not arriving right now is stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard <= '0;
        end else if (redirect_valid) begin
            discard <= outstanding - credit_t'(imem_resp_valid);
        end else if (imem_resp_valid && (discard != '0)) begin
            discard <= discard - credit_t'(1);
        end
    end

    // PC tags of live in-flight requests; stale ones are never popped,
    // so the queue is simply reset on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (req_fire) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + TAG_ONE;
            end
            if (resp_live) begin
                tag_rd <= tag_rd + TAG_ONE;
            end
        end
    end

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (resp_live),
        .push_entry (push_entry),
        .pop        (inst_valid && inst_ready),
        .flush      (redirect_valid),
        .head       (head),
        .count      (buf_count)
    );

    // Remember the last presented pair so the decoder sees stable values
    // while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_entry <= '0;
        end else if (buf_count != '0) begin
            last_entry <= head;
        end
    end

    assign inst_valid = (buf_count != '0);
    assign inst_code  = inst_valid ? head.code : last_entry.code;
    assign inst_pc    = inst_valid ? head.pc   : last_entry.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    // Sticky until the next redirect, which re-evaluates alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_fault = fault_q;
    assign req_block   = fault_q;
`else
    assign req_block = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural instruction memory
// answers accepted requests after a programmable latency; every response
// that should survive is pushed to a scoreboard and popped when the decoder
// handshake fires. Request addresses are checked against an independent
// expected-PC counter. Build with FETCH_MISALIGN_TRAP_EN to cover the trap.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_code       (inst_code),
        .inst_pc         (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    int checkCount = 0;
    int failCount  = 0;

    // Single point of comparison: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Memory contents: address-dependent so every word is distinguishable
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t       pendQ[$];
    logic [63:0] expQ[$];
    int          cyc = 0;
    int          memLatency = 1;
    int          lastDue = 0;
    int          epoch = 0;
    int          fireCount = 0;
    logic [31:0] expReqPc = RESET_PC;
    logic        prevStall = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] respAddrV = '0;
    int          respEpochV = 0;

    // Memory model plus scoreboard: observe at negedge, drive after posedge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pendQ.delete();
                expQ.delete();
                epoch     = 0;
                fireCount = 0;
                expReqPc  = RESET_PC;
                prevStall = 1'b0;
                lastDue   = cyc;
            end else begin
                if (inst_valid && inst_ready) begin
                    checkOutput("sb_avail", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        logic [63:0] e;
                        e = expQ.pop_front();
                        checkOutput("inst_pc", inst_pc, e[63:32]);
                        checkOutput("inst_code", inst_code, e[31:0]);
                    end
                end
                if (prevStall && !redirect_valid) begin
                    checkOutput("req_hold_valid", 32'(imem_req_valid), 32'd1);
                    checkOutput("req_hold_addr", imem_req_addr, prevAddr);
                end
                prevStall = imem_req_valid && !imem_req_ready;
                prevAddr  = imem_req_addr;
                if (imem_resp_valid && !redirect_valid && respEpochV == epoch) begin
                    expQ.push_back({respAddrV, memWord(respAddrV)});
                end
                if (redirect_valid) begin
                    expQ.delete();
                    epoch++;
                    expReqPc = redirect_pc & 32'hFFFF_FFFC;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend_t p;
                    checkOutput("req_addr", imem_req_addr, expReqPc);
                    expReqPc = expReqPc + 32'd4;
                    fireCount++;
                    p.addr  = imem_req_addr;
                    p.epoch = epoch;
                    p.due   = cyc + memLatency;
                    if (p.due <= lastDue) p.due = lastDue + 1;
                    lastDue = p.due;
                    pendQ.push_back(p);
                end
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (pendQ.size() != 0 && pendQ[0].due <= cyc + 1) begin
                pend_t p;
                p = pendQ.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = memWord(p.addr);
                respAddrV       = p.addr;
                respEpochV      = p.epoch;
            end
        end
    end

    // Drive one set of inputs; a redirect lasts only the first cycle
    task automatic applyStimulus(input logic memReady, input logic decReady,
                                 input logic redirValid, input logic [31:0] redirPc,
                                 input int cycles);
        imem_req_ready = memReady;
        inst_ready     = decReady;
        redirect_valid = redirValid;
        redirect_pc    = redirPc;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
        end
    endtask

    initial begin
        int fcSnap;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_code", inst_code, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);

        // Release: first request immediately, first instruction two cycles later
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("first_req_addr", imem_req_addr, RESET_PC);
        checkOutput("first_inst_valid_c0", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("first_inst_valid_c1", 32'(inst_valid), 32'd0);
        @(negedge clk);
        checkOutput("first_inst_valid_c2", 32'(inst_valid), 32'd1);
        checkOutput("first_inst_pc", inst_pc, RESET_PC);
        checkOutput("first_inst_code", inst_code, memWord(RESET_PC));

        // Decoder stalled: fetching stops after DEPTH requests
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 7);
        @(negedge clk);
        checkOutput("stall_fire_count", 32'(fireCount), 32'(DEPTH));
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);

        // Decoder released: in-order delivery and fetch resumes
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 20);

        // Slow memory so two requests are in flight, then redirect
        memLatency = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100, 20);
        memLatency = 1;

        // Redirects at varying phases, hitting response/handshake overlaps
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 3 + i);
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400 + 32'(i * 64), 1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6);

        // Memory ready toggling: address must hold while stalled
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'(i % 2), 1'b1, 1'b0, 32'h0, 1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps and blocks fetching
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0102, 5);
        @(negedge clk);
        checkOutput("fault_set", 32'(fetch_fault), 32'd1);
        fcSnap = fireCount;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6);
        @(negedge clk);
        checkOutput("fault_no_fires", 32'(fireCount), 32'(fcSnap));
        checkOutput("fault_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
        @(negedge clk);
        checkOutput("fault_clear", 32'(fetch_fault), 32'd0);
        checkOutput("fault_resume_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("fault_resume_addr", imem_req_addr, 32'h0000_0200);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 10);
`else
        // Misaligned redirect target is silently aligned
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_010E, 1);
        @(negedge clk);
        checkOutput("align_req_addr", imem_req_addr, 32'h0000_010C);
        fcSnap = fireCount;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 10);
        @(negedge clk);
        checkOutput("align_progress", 32'(fireCount > fcSnap), 32'd1);
        @(posedge clk);
        #1;
`endif

        // Reset mid-operation clears everything at once
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("midrst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
